counter: RTL and testbench

- Parameterized synchronous up/down counter with synchronous clear, parallel load and count enable.
- Used as a free-running cycle counter: a 32-bit instance with en=1, up=1, load=0 and D=0.
- The ring interconnect derives a divided node clock from a low bit of Q.
- Generic utility block; no protocol knowledge.

---
 rtl/counter.sv | 63 ++++++
 tb/tb_counter.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/counter.sv
// Parameterized up/down counter with synchronous clear, parallel load, count enable and optional saturation.
// Q and wrap are registered (one cycle after the controlling edge); at_max/at_zero decode Q combinationally.
module counter #(
  parameter int unsigned           WIDTH       = 32,
  parameter logic [WIDTH-1:0]      RESET_VALUE = '0,
  parameter bit                    SATURATE    = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] D,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] Q,
  output logic             wrap,
  output logic             at_max,
  output logic             at_zero
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;

  // Returns {wrap, next}; at a boundary either wraps (flagging it) or holds when saturating.
  function automatic logic [WIDTH:0] next_count(input logic [WIDTH-1:0] cur, input logic dir);
    logic             at_bound;
    logic [WIDTH-1:0] stepped;
    at_bound = dir ? (&cur) : (cur == '0);
    stepped  = dir ? (cur + WIDTH'(1)) : (cur - WIDTH'(1));
    if (at_bound && SATURATE) begin
      return {1'b0, cur};
    end
    return {at_bound, stepped};
  endfunction

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (clear) begin
      count_d = RESET_VALUE;
    end else if (load) begin
      count_d = D;
    end else if (en) begin
      {wrap_d, count_d} = next_count(count_q, up);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= RESET_VALUE;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign Q       = count_q;
  assign wrap    = wrap_q;
  assign at_max  = &count_q;
  assign at_zero = (count_q == '0);

endmodule

// File: tb/tb_counter.sv
// Directed bench for counter: free-run, wrap up/down, priority, saturation, hold and mid-count reset.
module tb_counter;

  logic        clock = 1'b0;
  logic        reset, clear, load, en, up;
  logic [31:0] d;

  logic [31:0] q32;
  logic        wrap32, max32, zero32;
  logic [3:0]  q4;
  logic        wrap4, max4, zero4;
  logic [7:0]  q8;
  logic        wrap8, max8, zero8;
  logic [3:0]  qs;
  logic        wraps, maxs, zeros;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  counter #(.WIDTH(32)) u_c32 (
    .clock(clock), .reset(reset), .clear(clear), .load(load), .D(d), .en(en), .up(up),
    .Q(q32), .wrap(wrap32), .at_max(max32), .at_zero(zero32)
  );

  counter #(.WIDTH(4)) u_c4 (
    .clock(clock), .reset(reset), .clear(clear), .load(load), .D(d[3:0]), .en(en), .up(up),
    .Q(q4), .wrap(wrap4), .at_max(max4), .at_zero(zero4)
  );

  counter #(.WIDTH(8), .RESET_VALUE(8'h0A)) u_c8 (
    .clock(clock), .reset(reset), .clear(clear), .load(load), .D(d[7:0]), .en(en), .up(up),
    .Q(q8), .wrap(wrap8), .at_max(max8), .at_zero(zero8)
  );

  counter #(.WIDTH(4), .SATURATE(1'b1)) u_sat (
    .clock(clock), .reset(reset), .clear(clear), .load(load), .D(d[3:0]), .en(en), .up(up),
    .Q(qs), .wrap(wraps), .at_max(maxs), .at_zero(zeros)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Advance one rising edge and settle before sampling or driving.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; load = 1'b0; en = 1'b0; up = 1'b1; d = '0;
    #1;
    step();
    step();
    check("rst_q32", q32, 32'd0);
    check("rst_wrap32", {31'd0, wrap32}, 32'd0);
    check("rst_zero32", {31'd0, zero32}, 32'd1);
    check("rst_q8", {24'd0, q8}, 32'h0A);
    check("rst_max4", {31'd0, max4}, 32'd0);

    // Free-running cycle counter.
    reset = 1'b0; en = 1'b1; up = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      check("free_q", q32, i);
      check("free_q1", {31'd0, q32[1]}, (i >> 1) & 1);
    end

    // Wrap up at WIDTH=4.
    load = 1'b1; en = 1'b0; d = 32'hE;
    step();
    check("ld_e", {28'd0, q4}, 32'hE);
    load = 1'b0; en = 1'b1; up = 1'b1;
    step();
    check("up_f", {28'd0, q4}, 32'hF);
    check("up_f_max", {31'd0, max4}, 32'd1);
    check("up_f_wrap", {31'd0, wrap4}, 32'd0);
    step();
    check("up_0", {28'd0, q4}, 32'h0);
    check("up_0_wrap", {31'd0, wrap4}, 32'd1);
    check("up_0_max", {31'd0, max4}, 32'd0);
    step();
    check("up_1", {28'd0, q4}, 32'h1);
    check("up_1_wrap", {31'd0, wrap4}, 32'd0);

    // Wrap down at WIDTH=4.
    load = 1'b1; en = 1'b0; d = 32'h1;
    step();
    check("ld_1", {28'd0, q4}, 32'h1);
    load = 1'b0; en = 1'b1; up = 1'b0;
    step();
    check("dn_0", {28'd0, q4}, 32'h0);
    check("dn_0_zero", {31'd0, zero4}, 32'd1);
    check("dn_0_wrap", {31'd0, wrap4}, 32'd0);
    step();
    check("dn_f", {28'd0, q4}, 32'hF);
    check("dn_f_wrap", {31'd0, wrap4}, 32'd1);
    check("dn_f_zero", {31'd0, zero4}, 32'd0);
    step();
    check("dn_e", {28'd0, q4}, 32'hE);
    check("dn_e_wrap", {31'd0, wrap4}, 32'd0);

    // Priority: clear over load over count.
    clear = 1'b1; load = 1'b1; d = 32'h55; en = 1'b1; up = 1'b1;
    step();
    check("pri_clear", {24'd0, q8}, 32'h0A);
    check("pri_clear_wrap", {31'd0, wrap8}, 32'd0);
    clear = 1'b0;
    step();
    check("pri_load", {24'd0, q8}, 32'h55);
    load = 1'b0;
    step();
    check("pri_count", {24'd0, q8}, 32'h56);

    // Saturation.
    load = 1'b1; d = 32'hF;
    step();
    check("sat_ld_f", {28'd0, qs}, 32'hF);
    load = 1'b0; en = 1'b1; up = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check("sat_up_q", {28'd0, qs}, 32'hF);
      check("sat_up_wrap", {31'd0, wraps}, 32'd0);
    end
    load = 1'b1; d = 32'h0;
    step();
    check("sat_ld_0", {28'd0, qs}, 32'h0);
    load = 1'b0; up = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      check("sat_dn_q", {28'd0, qs}, 32'h0);
      check("sat_dn_wrap", {31'd0, wraps}, 32'd0);
    end

    // Hold, then reset mid-count.
    load = 1'b1; d = 32'h7;
    step();
    load = 1'b0; en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_q8", {24'd0, q8}, 32'h07);
    end
    en = 1'b1; up = 1'b1; reset = 1'b1;
    step();
    check("mid_rst_q8", {24'd0, q8}, 32'h0A);
    check("mid_rst_q32", q32, 32'd0);
    reset = 1'b0;
    step();
    check("resume_q8", {24'd0, q8}, 32'h0B);
    step();
    check("resume2_q8", {24'd0, q8}, 32'h0C);
    check("resume2_q32", q32, 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
